// File: rtl/axi_stream_ddr_writer_pkg.sv
// Shared types and AXI constants for the stream-to-DDR burst writer.
package axi_stream_ddr_writer_pkg;

    // Burst sequencing states; the writer holds at most one burst in flight.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AW   = 2'd1,
        ST_W    = 2'd2,
        ST_B    = 2'd3
    } state_t;

    typedef logic [31:0] word_t;

    localparam logic [2:0] C_AXI_SIZE_4B    = 3'b010;   // 4 bytes per beat
    localparam logic [1:0] C_AXI_BURST_INCR = 2'b01;
    localparam logic [3:0] C_AXI_CACHE      = 4'b0011;  // bufferable, modifiable
    localparam logic [1:0] C_AXI_RESP_OKAY  = 2'b00;

endpackage

// File: rtl/axi_stream_ddr_writer_if.sv
// AXI4 write-only channel bundle between the writer (master) and MIG port (slave).
interface axi_stream_ddr_writer_if;
    import axi_stream_ddr_writer_pkg::*;

    word_t       m_axi_awaddr;
    logic [7:0]  m_axi_awlen;
    logic [2:0]  m_axi_awsize;
    logic [1:0]  m_axi_awburst;
    logic        m_axi_awlock;
    logic [3:0]  m_axi_awcache;
    logic [2:0]  m_axi_awprot;
    logic [3:0]  m_axi_awqos;
    logic        m_axi_awvalid;
    logic        m_axi_awready;
    word_t       m_axi_wdata;
    logic [3:0]  m_axi_wstrb;
    logic        m_axi_wlast;
    logic        m_axi_wvalid;
    logic        m_axi_wready;
    logic [1:0]  m_axi_bresp;
    logic        m_axi_bvalid;
    logic        m_axi_bready;

    modport master (
        output m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst,
               m_axi_awlock, m_axi_awcache, m_axi_awprot, m_axi_awqos,
               m_axi_awvalid, m_axi_wdata, m_axi_wstrb, m_axi_wlast,
               m_axi_wvalid, m_axi_bready,
        input  m_axi_awready, m_axi_wready, m_axi_bresp, m_axi_bvalid
    );

    modport slave (
        input  m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst,
               m_axi_awlock, m_axi_awcache, m_axi_awprot, m_axi_awqos,
               m_axi_awvalid, m_axi_wdata, m_axi_wstrb, m_axi_wlast,
               m_axi_wvalid, m_axi_bready,
        output m_axi_awready, m_axi_wready, m_axi_bresp, m_axi_bvalid
    );

endinterface

// File: rtl/axi_stream_ddr_writer_sync_fifo_fwft.sv
// First-word-fall-through synchronous FIFO with exact full/empty and occupancy count.
module sync_fifo_fwft
    import axi_stream_ddr_writer_pkg::*;
#(
    parameter int P_WIDTH = 32,
    parameter int P_DEPTH = 64
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_push,
    input  logic [P_WIDTH-1:0]         i_data,
    input  logic                       i_pop,
    output logic [P_WIDTH-1:0]         o_data,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(P_DEPTH):0]   o_count
);

    localparam int C_AW = $clog2(P_DEPTH);

    logic [P_WIDTH-1:0] mem_q [P_DEPTH];
    // One extra pointer bit distinguishes full from empty when the indices match.
    logic [C_AW:0]      wr_ptr_q;
    logic [C_AW:0]      rd_ptr_q;
    logic               do_push;
    logic               do_pop;

    assign o_count = wr_ptr_q - rd_ptr_q;
    assign o_full  = (o_count == (C_AW+1)'(P_DEPTH));
    assign o_empty = (o_count == '0);
    assign do_push = i_push & ~o_full;
    assign do_pop  = i_pop & ~o_empty;

    // Head word is read asynchronously so it is visible without a prefetch cycle.
    assign o_data = mem_q[rd_ptr_q[C_AW-1:0]];

    // Pointer update; reset drops all stored words.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // Storage write at the tail.
    always_ff @(posedge i_clk) begin
        if (do_push) mem_q[wr_ptr_q[C_AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/axi_stream_ddr_writer.sv
// Buffers a 32-bit sample stream and writes it as AXI4 INCR bursts into a circular DDR region.
module axi_stream_ddr_writer
    import axi_stream_ddr_writer_pkg::*;
#(
    parameter int          P_BURST_LEN    = 16,
    parameter int          P_FIFO_DEPTH   = 64,
    parameter logic [31:0] P_BASE_ADDR    = 32'h0000_0000,
    parameter logic [31:0] P_REGION_BYTES = 32'h0010_0000
) (
    input  logic                            i_clk,
    input  logic                            i_rst_n,
    input  logic                            i_init_calib_complete,
    input  logic [31:0]                     i_data,
    input  logic                            i_valid,
    output logic                            o_ready,
    axi_stream_ddr_writer_if.master         m_axi,
    output logic [31:0]                     o_burst_cnt,
    output logic                            o_err
);

    localparam int          C_CNT_W       = $clog2(P_FIFO_DEPTH) + 1;
    localparam logic [31:0] C_BURST_BYTES = 32'(P_BURST_LEN * 4);
    localparam logic [31:0] C_REGION_END  = P_BASE_ADDR + P_REGION_BYTES;
    localparam logic [7:0]  C_LAST_BEAT   = 8'(P_BURST_LEN - 1);

    state_t               state_q;
    logic                 awvalid_q;
    logic                 wvalid_q;
    logic                 wlast_q;
    logic                 bready_q;
    word_t                awaddr_q;
    logic [31:0]          burst_cnt_q;
    logic                 err_q;
    logic [7:0]           beat_q;

    logic                 fifo_full;
    logic                 fifo_empty;
    logic [C_CNT_W-1:0]   fifo_count;
    word_t                fifo_head;
    logic                 push;
    logic                 pop;
    logic [C_CNT_W:0]     level_d;
    logic                 burst_avail_d;
    word_t                awaddr_step_d;
    word_t                awaddr_next_d;

    // Reset also gates ready so the stream sees no acceptance while the block is held.
    assign o_ready = i_rst_n & i_init_calib_complete & ~fifo_full;
    assign push    = i_valid & o_ready;
    assign pop     = wvalid_q & m_axi.m_axi_wready & ~fifo_empty;

    // Counting this cycle's push lets a just-completed burst raise awvalid one cycle later.
    assign level_d       = {1'b0, fifo_count} + (C_CNT_W+1)'(push);
    assign burst_avail_d = i_init_calib_complete & (level_d >= (C_CNT_W+1)'(P_BURST_LEN));

    assign awaddr_step_d = awaddr_q + C_BURST_BYTES;
    assign awaddr_next_d = (awaddr_step_d == C_REGION_END) ? P_BASE_ADDR : awaddr_step_d;

    sync_fifo_fwft #(
        .P_WIDTH (32),
        .P_DEPTH (P_FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (push),
        .i_data  (i_data),
        .i_pop   (pop),
        .o_data  (fifo_head),
        .o_full  (fifo_full),
        .o_empty (fifo_empty),
        .o_count (fifo_count)
    );

    // Burst sequencer: address, data beats and response strictly one after another.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q     <= ST_IDLE;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            wlast_q     <= 1'b0;
            bready_q    <= 1'b0;
            awaddr_q    <= P_BASE_ADDR;
            burst_cnt_q <= '0;
            err_q       <= 1'b0;
            beat_q      <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (burst_avail_d) begin
                        awvalid_q <= 1'b1;
                        state_q   <= ST_AW;
                    end
                end
                ST_AW: begin
                    if (m_axi.m_axi_awready) begin
                        awvalid_q <= 1'b0;
                        wvalid_q  <= 1'b1;
                        wlast_q   <= (C_LAST_BEAT == 8'd0);
                        beat_q    <= '0;
                        state_q   <= ST_W;
                    end
                end
                ST_W: begin
                    if (m_axi.m_axi_wready) begin
                        if (wlast_q) begin
                            wvalid_q <= 1'b0;
                            wlast_q  <= 1'b0;
                            bready_q <= 1'b1;
                            state_q  <= ST_B;
                        end else begin
                            beat_q  <= beat_q + 8'd1;
                            wlast_q <= ((beat_q + 8'd1) == C_LAST_BEAT);
                        end
                    end
                end
                ST_B: begin
                    if (m_axi.m_axi_bvalid) begin
                        bready_q    <= 1'b0;
                        burst_cnt_q <= burst_cnt_q + 32'd1;
                        err_q       <= err_q | (m_axi.m_axi_bresp != C_AXI_RESP_OKAY);
                        awaddr_q    <= awaddr_next_d;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign m_axi.m_axi_awaddr  = awaddr_q;
    assign m_axi.m_axi_awlen   = C_LAST_BEAT;
    assign m_axi.m_axi_awsize  = C_AXI_SIZE_4B;
    assign m_axi.m_axi_awburst = C_AXI_BURST_INCR;
    assign m_axi.m_axi_awlock  = 1'b0;
    assign m_axi.m_axi_awcache = C_AXI_CACHE;
    assign m_axi.m_axi_awprot  = 3'b000;
    assign m_axi.m_axi_awqos   = 4'b0000;
    assign m_axi.m_axi_awvalid = awvalid_q;
    assign m_axi.m_axi_wdata   = fifo_head;
    assign m_axi.m_axi_wstrb   = 4'hF;
    assign m_axi.m_axi_wlast   = wlast_q;
    assign m_axi.m_axi_wvalid  = wvalid_q;
    assign m_axi.m_axi_bready  = bready_q;

    assign o_burst_cnt = burst_cnt_q;
    assign o_err       = err_q;

endmodule

// File: tb/tb_axi_stream_ddr_writer.sv
// Randomized bench for axi_stream_ddr_writer with a queue-based reference model.
module tb_axi_stream_ddr_writer;
    import axi_stream_ddr_writer_pkg::*;

    localparam int          LEN    = 16;
    localparam int          DEPTH  = 64;
    localparam logic [31:0] BASE   = 32'h0000_0000;
    localparam logic [31:0] REGION = 32'h0000_0100;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        calib = 1'b0;
    logic [31:0] i_data = '0;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic [31:0] burst_cnt;
    logic        err;

    axi_stream_ddr_writer_if axi_bus();

    axi_stream_ddr_writer #(
        .P_BURST_LEN    (LEN),
        .P_FIFO_DEPTH   (DEPTH),
        .P_BASE_ADDR    (BASE),
        .P_REGION_BYTES (REGION)
    ) dut (
        .i_clk                 (i_clk),
        .i_rst_n               (i_rst_n),
        .i_init_calib_complete (calib),
        .i_data                (i_data),
        .i_valid               (i_valid),
        .o_ready               (o_ready),
        .m_axi                 (axi_bus),
        .o_burst_cnt           (burst_cnt),
        .o_err                 (err)
    );

    always #5 i_clk = ~i_clk;

    int errors = 0;
    int checks = 0;

    // Slave behaviour knobs
    int aw_stall = 0;
    int w_stall  = 0;
    int b_stall  = 0;
    int bad_idx  = -1;

    // Reference model state and transaction logs
    logic [31:0] exp_data [$];
    logic [31:0] w_log [$];
    logic [31:0] aw_log [$];
    int n_push = 0, n_pop = 0, b_count = 0;
    int stab_viol = 0, proto_viol = 0, full_viol = 0;
    bit saw_full = 0;

    task automatic clear_logs();
        exp_data.delete(); w_log.delete(); aw_log.delete();
        n_push = 0; n_pop = 0; b_count = 0;
        stab_viol = 0; proto_viol = 0; full_viol = 0; saw_full = 0;
    endtask

    // Slave responder and monitor: decides ready/response for the coming edge, then records handshakes.
    initial begin : monitor
        bit          aw_pend = 0, w_pend = 0, aw_acc = 0;
        logic [31:0] aw_pend_addr = '0, w_pend_data = '0, cur_addr = '0;
        bit          w_pend_last = 0;
        int          beat = 0;
        int          occ;
        axi_bus.m_axi_awready = 1'b0;
        axi_bus.m_axi_wready  = 1'b0;
        axi_bus.m_axi_bvalid  = 1'b0;
        axi_bus.m_axi_bresp   = 2'b00;
        forever begin
            @(negedge i_clk);
            axi_bus.m_axi_awready = ($urandom_range(99) >= aw_stall);
            axi_bus.m_axi_wready  = ($urandom_range(99) >= w_stall);
            axi_bus.m_axi_bvalid  = axi_bus.m_axi_bready && ($urandom_range(99) >= b_stall);
            axi_bus.m_axi_bresp   = (b_count == bad_idx) ? 2'b10 : 2'b00;
            #1;
            if (!i_rst_n) begin
                aw_pend = 0; w_pend = 0; aw_acc = 0; beat = 0;
            end else begin
                if (aw_pend && (!axi_bus.m_axi_awvalid || axi_bus.m_axi_awaddr !== aw_pend_addr))
                    stab_viol++;
                if (w_pend && (!axi_bus.m_axi_wvalid || axi_bus.m_axi_wdata !== w_pend_data ||
                               axi_bus.m_axi_wlast !== w_pend_last))
                    stab_viol++;
                if (axi_bus.m_axi_wvalid && !aw_acc) proto_viol++;
                if (axi_bus.m_axi_awvalid && axi_bus.m_axi_wvalid) proto_viol++;
                occ = n_push - n_pop;
                if (occ == DEPTH) saw_full = 1;
                if (occ == DEPTH && o_ready) full_viol++;
                if (occ < DEPTH && calib && !o_ready) full_viol++;
                if (axi_bus.m_axi_awvalid && axi_bus.m_axi_awready) begin
                    aw_log.push_back(axi_bus.m_axi_awaddr);
                    cur_addr = axi_bus.m_axi_awaddr;
                    aw_acc = 1; beat = 0;
                end
                aw_pend      = axi_bus.m_axi_awvalid && !axi_bus.m_axi_awready;
                aw_pend_addr = axi_bus.m_axi_awaddr;
                if (axi_bus.m_axi_wvalid && axi_bus.m_axi_wready) begin
                    w_log.push_back(axi_bus.m_axi_wdata);
                    n_pop++;
                    if (axi_bus.m_axi_wlast !== (beat == LEN-1)) proto_viol++;
                    beat++;
                    if (axi_bus.m_axi_wlast) aw_acc = 0;
                end
                w_pend      = axi_bus.m_axi_wvalid && !axi_bus.m_axi_wready;
                w_pend_data = axi_bus.m_axi_wdata;
                w_pend_last = axi_bus.m_axi_wlast;
                if (axi_bus.m_axi_bready && axi_bus.m_axi_bvalid) begin
                    $display("burst %0d: awaddr=0x%08h bresp=%0d", b_count, cur_addr, axi_bus.m_axi_bresp);
                    b_count++;
                end
                if (i_valid && o_ready) begin
                    exp_data.push_back(i_data);
                    n_push++;
                end
            end
        end
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation time limit reached (got hang, required completion)");
        $fatal(1, "watchdog");
    end

    // Expected burst address from the circular-region rule.
    function automatic logic [31:0] exp_addr(int k);
        return BASE + ((k * LEN * 4) % REGION);
    endfunction

    function automatic int data_mism();
        int m = 0;
        for (int i = 0; i < w_log.size(); i++)
            if (i >= exp_data.size() || w_log[i] !== exp_data[i]) m++;
        return m;
    endfunction

    function automatic int addr_mism();
        int m = 0;
        for (int k = 0; k < aw_log.size(); k++)
            if (aw_log[k] !== exp_addr(k)) m++;
        return m;
    endfunction

    task automatic do_reset();
        @(negedge i_clk);
        i_valid = 0; i_rst_n = 0;
        repeat (2) @(negedge i_clk);
        i_rst_n = 1;
        clear_logs();
    endtask

    task automatic push_words(input int n, input bit rnd, input logic [31:0] start,
                              input int gap_pct, input int budget, output bit ok);
        int sent = 0, cyc = 0;
        logic [31:0] d;
        d = rnd ? $urandom : start;
        while (sent < n && cyc < budget) begin
            @(negedge i_clk);
            cyc++;
            i_valid = ($urandom_range(99) >= gap_pct);
            i_data  = d;
            #1;
            if (i_valid && o_ready) begin
                sent++;
                d = rnd ? $urandom : d + 32'd1;
            end
        end
        @(negedge i_clk);
        i_valid = 0;
        ok = (sent == n);
    endtask

    task automatic wait_bursts(input int target, input int budget, output bit ok);
        int cyc = 0;
        while (b_count < target && cyc < budget) begin
            @(negedge i_clk);
            #2;
            cyc++;
        end
        ok = (b_count >= target);
        @(negedge i_clk);
        #2;
    endtask

    task automatic test_reset();
        int bad = 0;
        calib = 0; i_valid = 1; i_data = 32'hDEAD_BEEF; i_rst_n = 0;
        repeat (3) @(negedge i_clk);
        i_rst_n = 1;
        clear_logs();
        repeat (20) begin
            @(negedge i_clk);
            #2;
            if (o_ready || axi_bus.m_axi_awvalid || axi_bus.m_axi_wvalid || axi_bus.m_axi_bready) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL reset_idle: active cycles=%0d required 0", bad); end
        checks++; if (axi_bus.m_axi_awaddr !== BASE) begin errors++; $display("FAIL reset_awaddr: got 0x%08h required 0x%08h", axi_bus.m_axi_awaddr, BASE); end
        checks++; if (burst_cnt !== 32'd0) begin errors++; $display("FAIL reset_burst_cnt: got %0d required 0", burst_cnt); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %0b required 0", err); end
        checks++; if (axi_bus.m_axi_wlast !== 1'b0) begin errors++; $display("FAIL reset_wlast: got %0b required 0", axi_bus.m_axi_wlast); end
        checks++; if (aw_log.size() !== 0) begin errors++; $display("FAIL reset_no_aw: got %0d bursts required 0", aw_log.size()); end
        checks++; if ({axi_bus.m_axi_awlen, axi_bus.m_axi_awsize, axi_bus.m_axi_awburst, axi_bus.m_axi_awcache, axi_bus.m_axi_wstrb}
                      !== {8'd15, 3'b010, 2'b01, 4'b0011, 4'hF}) begin
            errors++; $display("FAIL reset_consts: got len=%0d size=%0d burst=%0d cache=%0h strb=%0h required 15/2/1/3/f",
                axi_bus.m_axi_awlen, axi_bus.m_axi_awsize, axi_bus.m_axi_awburst, axi_bus.m_axi_awcache, axi_bus.m_axi_wstrb);
        end
        i_valid = 0;
    endtask

    task automatic test_single_burst();
        bit ok;
        calib = 1; aw_stall = 0; w_stall = 0; b_stall = 0;
        push_words(16, 0, 32'h0, 0, 200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL single_push: got incomplete push required 16 words"); end
        #1;
        checks++; if (axi_bus.m_axi_awvalid !== 1'b1) begin errors++; $display("FAIL single_aw_latency: got awvalid=%0b required 1", axi_bus.m_axi_awvalid); end
        wait_bursts(1, 200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL single_timeout: got %0d responses required 1", b_count); end
        checks++; if (aw_log.size() !== 1 || aw_log[0] !== BASE) begin errors++; $display("FAIL single_aw: got %0d bursts required 1 at 0x%08h", aw_log.size(), BASE); end
        checks++; if (w_log.size() !== 16) begin errors++; $display("FAIL single_beats: got %0d required 16", w_log.size()); end
        checks++; if (data_mism() !== 0) begin errors++; $display("FAIL single_data: got %0d mismatches required 0", data_mism()); end
        checks++; if (proto_viol !== 0) begin errors++; $display("FAIL single_wlast: got %0d protocol errors required 0", proto_viol); end
        checks++; if (burst_cnt !== 32'd1) begin errors++; $display("FAIL single_burst_cnt: got %0d required 1", burst_cnt); end
    endtask

    task automatic test_wrap();
        bit ok;
        do_reset();
        push_words(80, 0, 32'h100, 0, 400, ok);
        wait_bursts(5, 400, ok);
        checks++; if (!ok || aw_log.size() !== 5) begin errors++; $display("FAIL wrap_count: got %0d bursts required 5", aw_log.size()); end
        for (int k = 0; k < 5 && k < aw_log.size(); k++) begin
            checks++;
            if (aw_log[k] !== exp_addr(k)) begin errors++; $display("FAIL wrap_addr%0d: got 0x%08h required 0x%08h", k, aw_log[k], exp_addr(k)); end
        end
        checks++; if (data_mism() !== 0 || w_log.size() !== 80) begin errors++; $display("FAIL wrap_data: got %0d mismatches over %0d beats required 0 over 80", data_mism(), w_log.size()); end
        checks++; if (burst_cnt !== 32'd5) begin errors++; $display("FAIL wrap_burst_cnt: got %0d required 5", burst_cnt); end
    endtask

    task automatic test_stall_stream();
        bit ok_p, ok_w;
        do_reset();
        aw_stall = 40; w_stall = 50; b_stall = 40;
        push_words(1024, 1, 32'h0, 0, 20000, ok_p);
        wait_bursts(64, 5000, ok_w);
        aw_stall = 0; w_stall = 0; b_stall = 0;
        checks++; if (!ok_p || !ok_w) begin errors++; $display("FAIL stall_timeout: got push_ok=%0b bursts=%0d required 1/64", ok_p, b_count); end
        checks++; if (w_log.size() !== 1024) begin errors++; $display("FAIL stall_beats: got %0d required 1024", w_log.size()); end
        checks++; if (data_mism() !== 0) begin errors++; $display("FAIL stall_data: got %0d mismatches required 0", data_mism()); end
        checks++; if (addr_mism() !== 0) begin errors++; $display("FAIL stall_addr: got %0d mismatches required 0", addr_mism()); end
        checks++; if (stab_viol !== 0) begin errors++; $display("FAIL stall_stable: got %0d violations required 0", stab_viol); end
        checks++; if (proto_viol !== 0) begin errors++; $display("FAIL stall_protocol: got %0d violations required 0", proto_viol); end
        checks++; if (full_viol !== 0) begin errors++; $display("FAIL stall_ready_full: got %0d violations required 0", full_viol); end
        checks++; if (saw_full !== 1'b1) begin errors++; $display("FAIL stall_reached_full: got %0b required 1", saw_full); end
        checks++; if (burst_cnt !== 32'd64) begin errors++; $display("FAIL stall_burst_cnt: got %0d required 64", burst_cnt); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL stall_err: got %0b required 0", err); end
    endtask

    task automatic test_bresp_err();
        bit ok;
        do_reset();
        aw_stall = 20; w_stall = 20; b_stall = 20; bad_idx = 2;
        push_words(32, 1, 32'h0, 10, 400, ok);
        wait_bursts(2, 400, ok);
        checks++; if (!ok || err !== 1'b0) begin errors++; $display("FAIL bresp_before: got err=%0b bursts=%0d required 0/2", err, b_count); end
        push_words(48, 1, 32'h0, 10, 600, ok);
        wait_bursts(5, 600, ok);
        bad_idx = -1;
        checks++; if (!ok || burst_cnt !== 32'd5) begin errors++; $display("FAIL bresp_count: got %0d required 5", burst_cnt); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL bresp_sticky: got err=%0b required 1", err); end
        checks++; if (data_mism() !== 0 || addr_mism() !== 0) begin errors++; $display("FAIL bresp_data: got %0d/%0d mismatches required 0", data_mism(), addr_mism()); end
        aw_stall = 0; w_stall = 0; b_stall = 0;
    endtask

    task automatic test_reset_midburst();
        bit ok;
        int cyc = 0;
        clear_logs();
        push_words(16, 0, 32'hA000, 0, 200, ok);
        while (w_log.size() < 8 && cyc < 200) begin
            @(negedge i_clk);
            #2;
            cyc++;
        end
        checks++; if (w_log.size() < 8) begin errors++; $display("FAIL mid_reach_beat8: got %0d beats required 8", w_log.size()); end
        i_rst_n = 0;
        @(negedge i_clk);
        #1;
        checks++; if ({axi_bus.m_axi_awvalid, axi_bus.m_axi_wvalid, axi_bus.m_axi_wlast, axi_bus.m_axi_bready, o_ready} !== 5'b0) begin
            errors++; $display("FAIL mid_valids: got aw=%0b w=%0b last=%0b b=%0b rdy=%0b required all 0", axi_bus.m_axi_awvalid,
                axi_bus.m_axi_wvalid, axi_bus.m_axi_wlast, axi_bus.m_axi_bready, o_ready);
        end
        checks++; if (axi_bus.m_axi_awaddr !== BASE) begin errors++; $display("FAIL mid_awaddr: got 0x%08h required 0x%08h", axi_bus.m_axi_awaddr, BASE); end
        checks++; if (burst_cnt !== 32'd0 || err !== 1'b0) begin errors++; $display("FAIL mid_counters: got cnt=%0d err=%0b required 0/0", burst_cnt, err); end
        @(negedge i_clk);
        i_rst_n = 1;
        clear_logs();
        push_words(16, 0, 32'hB000, 0, 200, ok);
        wait_bursts(1, 200, ok);
        repeat (30) @(negedge i_clk);
        #2;
        checks++; if (!ok || aw_log.size() !== 1 || aw_log[0] !== BASE) begin errors++; $display("FAIL mid_restart_aw: got %0d bursts required 1 at 0x%08h", aw_log.size(), BASE); end
        checks++; if (w_log.size() !== 16 || data_mism() !== 0) begin errors++; $display("FAIL mid_restart_data: got %0d beats %0d mismatches required 16/0", w_log.size(), data_mism()); end
        checks++; if (burst_cnt !== 32'd1) begin errors++; $display("FAIL mid_restart_cnt: got %0d required 1", burst_cnt); end
    endtask

    initial begin
        test_reset();
        test_single_burst();
        test_wrap();
        test_stall_stream();
        test_bresp_err();
        test_reset_midburst();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/axi_stream_ddr_writer.md
Name: axi_stream_ddr_writer

Overview:
- Upstream neighbour of the MIG/AXI interconnect slave port S01.
- Accepts a 32-bit valid/ready sample stream (e.g. DDS or Ethernet payload) into an internal FIFO.
- Once a full burst is buffered, issues one AXI4 INCR write burst into a circular DDR region.
- Write-only master. Read channels are not present and are tied off at the instantiation.

Parameters:
- P_BURST_LEN, 16, beats per AXI burst (1..256; P_BURST_LEN*4 must divide 4096).
- P_FIFO_DEPTH, 64, input FIFO depth in words (power of 2, >= 2*P_BURST_LEN).
- P_BASE_ADDR, 32'h0000_0000, region start byte address (aligned to P_BURST_LEN*4).
- P_REGION_BYTES, 32'h0010_0000, region size in bytes (multiple of P_BURST_LEN*4).

Ports:
- i_clk  in  1  UI clock from MIG
- i_rst_n  in  1  synchronous active-low reset
- i_init_calib_complete  in  1  MIG calibration done
- i_data  in  32  stream data
- i_valid  in  1  stream valid
- o_ready  out  1  stream ready
- m_axi_awaddr  out  32  burst start address
- m_axi_awlen  out  8  P_BURST_LEN-1
- m_axi_awsize  out  3  constant 3'b010
- m_axi_awburst  out  2  constant 2'b01
- m_axi_awlock  out  1  constant 0
- m_axi_awcache  out  4  constant 4'b0011
- m_axi_awprot  out  3  constant 0
- m_axi_awqos  out  4  constant 0
- m_axi_awvalid  out  1  address valid
- m_axi_awready  in  1  address ready
- m_axi_wdata  out  32  FIFO head word
- m_axi_wstrb  out  4  constant 4'hF
- m_axi_wlast  out  1  last beat
- m_axi_wvalid  out  1  data valid
- m_axi_wready  in  1  data ready
- m_axi_bresp  in  2  write response
- m_axi_bvalid  in  1  response valid
- m_axi_bready  out  1  response ready
- o_burst_cnt  out  32  completed bursts
- o_err  out  1  sticky, set on bresp != 2'b00

Behaviour:
- Reset (i_rst_n=0 at a clock edge) forces:
  - awvalid=0, wvalid=0, wlast=0, bready=0, o_ready=0
  - awaddr=P_BASE_ADDR, o_burst_cnt=0, o_err=0
  - FIFO emptied, FSM=ST_IDLE
- Reset mid-burst abandons the transaction without completing it.
- o_ready = i_init_calib_complete & !fifo_full. A word is pushed when i_valid & o_ready.
- FIFO is first-word-fall-through: m_axi_wdata always equals the head word. Push and pop in the same cycle are legal and leave the count unchanged. Full and empty flags are exact.
- FSM:
  - ST_IDLE: moves to ST_AW when calib=1 and fifo_count >= P_BURST_LEN.
  - ST_AW: awvalid=1 with awaddr held stable. On awready, moves to ST_W and clears the beat counter.
  - ST_W: wvalid=1 (data is guaranteed, since FIFO held >= P_BURST_LEN at entry and is drained only here). Each wvalid&wready pops one word and increments the beat counter. wlast=1 exactly when beat counter == P_BURST_LEN-1. When the wlast beat is accepted, moves to ST_B.
  - ST_B: bready=1. On bvalid:
    - o_burst_cnt += 1
    - o_err |= (bresp != 0)
    - awaddr += P_BURST_LEN*4; if the result equals P_BASE_ADDR+P_REGION_BYTES, awaddr wraps to P_BASE_ADDR
    - moves to ST_IDLE
- AW and W are strictly serialised: no W beat before AW is accepted. One outstanding burst at a time.
- Latency:
  - A burst buffered before ST_IDLE issues awvalid in the cycle after the last required push.
  - Back-to-back bursts have 1 idle cycle (ST_B to ST_IDLE to ST_AW).
- awvalid and wvalid are never deasserted before their handshake completes (AXI rule).
- Calibration loss while a burst is active does not abort the burst. It only blocks new bursts and drops o_ready.
- o_burst_cnt wraps modulo 2^32.

Decomposition:
- Shared package: FSM state encoding (ST_IDLE/ST_AW/ST_W/ST_B), AXI constants (size 3'b010, burst INCR 2'b01, cache 4'b0011, resp OKAY 2'b00).
- One sub-module, sync_fifo_fwft (32-bit, depth P_FIFO_DEPTH, outputs full/empty/count). The FSM and address logic stay in the top.

Test Plan:
- Reset with calib=0, drive i_valid=1 -> o_ready=0, no AW; all outputs stay at reset values.
- calib=1, push 16 words 0x0..0xF, slave always ready -> one AW at 0x0 with awlen=15; 16 W beats with data 0..15; wlast only on beat 16; o_burst_cnt=1.
- P_REGION_BYTES=0x100, push 5 bursts -> awaddr sequence 0x00, 0x40, 0x80, 0xC0, 0x00.
- Random awready/wready/bvalid stalls, plus a continuous push of 1024 words -> data in order, no loss; awvalid/wvalid stable while stalled; o_ready=0 whenever FIFO holds 64 words.
- Third response bresp=2'b10 -> o_err=1 and remains 1 after later OKAY responses.
- Assert i_rst_n=0 during beat 8 of a burst -> next cycle all valids=0, awaddr=P_BASE_ADDR, FIFO empty; a fresh 16-word push restarts cleanly at 0x0.
